// File: rtl/mult_div_pkg.sv
// mult_div_pkg: shared types and constants for the iterative multiply/divide unit.
//   op_e    : operation encoding carried on the 2-bit op input
//   state_e : sequencer states (also exported on the debug state output)
//   DATA_W  : default operand width; HI and LO are each DATA_W bits
//   STEPS   : radix-2 iterations per operation (one per operand bit)
package mult_div_pkg;

  localparam int DATA_W = 32;
  localparam int STEPS  = DATA_W;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    CALC = 2'b01,
    FIX  = 2'b10,
    DONE = 2'b11
  } state_e;

  // MULT and DIV work on magnitudes and need a sign fix afterwards.
  function automatic logic is_signed_op(op_e op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/mult_div_if.sv
// mult_div_if: request/result bundle between the execute stage and the
// multiply/divide unit.
//   start, op, rs, rt          : request from the pipeline (master drives)
//   busy, done, hi_out, lo_out : status and HI/LO result (slave drives)
//   dbg_state                  : current sequencer state, for observation only
//
// Handshake: a request is taken on a rising edge where start=1 and the unit is
// IDLE (busy=0); op/rs/rt only matter on that edge. Starts seen while busy are
// dropped. done is a single-cycle strobe meaning hi_out/lo_out must be written
// to HI/LO in that cycle; the results then hold until the next done.
interface mult_div_if
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DATA_W
) ();

  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] rs;
  logic [WIDTH-1:0] rt;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  state_e           dbg_state;

  modport master (
    output start, op, rs, rt,
    input  busy, done, hi_out, lo_out, dbg_state
  );

  modport slave (
    input  start, op, rs, rt,
    output busy, done, hi_out, lo_out, dbg_state
  );

endinterface

// File: rtl/mdu_step.sv
// mdu_step: one radix-2 iteration of the multiply/divide datapath, purely
// combinational.
//   is_div  : 0 = shift-add multiply step, 1 = restoring divide step
//   operand : multiplicand magnitude (multiply) or divisor magnitude (divide)
//   acc_i   : multiply: {partial product, remaining multiplier bits}
//             divide  : {partial remainder, remaining dividend / quotient bits}
//   acc_o   : accumulator after this iteration
module mdu_step #(
  parameter int WIDTH = 32
) (
  input  logic               is_div,
  input  logic [WIDTH-1:0]   operand,
  input  logic [2*WIDTH-1:0] acc_i,
  output logic [2*WIDTH-1:0] acc_o
);

  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   rem_sh;
  logic [WIDTH+1:0] trial;
  logic             unused_bits;

  always_comb begin
    // Multiply: add the multiplicand into the upper half when the multiplier
    // LSB is set, then shift the whole accumulator right with the carry.
    mul_sum = {1'b0, acc_i[2*WIDTH-1:WIDTH]} + (acc_i[0] ? {1'b0, operand} : '0);

    // Divide: shift the next dividend bit into the remainder, trial-subtract.
    rem_sh = acc_i[2*WIDTH-1:WIDTH-1];
    trial  = {1'b0, rem_sh} - {2'b00, operand};

    if (is_div) begin
      if (trial[WIDTH+1]) begin
        // Borrow: restore the shifted remainder, quotient bit 0.
        acc_o = {rem_sh[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b0};
      end else begin
        acc_o = {trial[WIDTH-1:0], acc_i[WIDTH-2:0], 1'b1};
      end
    end else begin
      acc_o = {mul_sum, acc_i[WIDTH-1:1]};
    end
  end

  // The remainder stays below the divisor, so these top bits are always zero
  // whenever they would be kept.
  assign unused_bits = ^{rem_sh[WIDTH], trial[WIDTH]};

endmodule

// File: rtl/mult_div_unit.sv
// mult_div_unit: iterative MULT/MULTU/DIV/DIVU unit producing the HI/LO pair.
//   clk      : rising-edge clock
//   reset_n  : asynchronous active-low reset
//   bus      : mult_div_if slave (start/op/rs/rt in; busy/done/hi_out/lo_out out)
//
// Schedule: IDLE --start--> CALC (WIDTH steps) -> FIX (sign correction) ->
// DONE (done=1, results registered on the edge entering DONE) -> IDLE.
// done appears WIDTH+1 cycles after the accepting edge. All iteration is on
// magnitudes; signs are reapplied only when leaving FIX.
module mult_div_unit
  import mult_div_pkg::*;
#(
  parameter int WIDTH = DATA_W
) (
  input  logic     clk,
  input  logic     reset_n,
  mult_div_if.slave bus
);

  localparam int W2    = 2 * WIDTH;
  localparam int CNT_W = $clog2(WIDTH);

  state_e           state_q, state_d;
  logic             is_div_q, is_div_d;
  logic             neg_res_q, neg_res_d;   // quotient / product gets negated
  logic             neg_rem_q, neg_rem_d;   // remainder gets negated (dividend < 0)
  logic [WIDTH-1:0] operand_q, operand_d;
  logic [W2-1:0]    acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;

  // Start-cycle operand conditioning.
  op_e              start_op;
  logic             start_signed;
  logic             start_div;
  logic             sign_rs, sign_rt;
  logic [WIDTH-1:0] abs_rs, abs_rt;

  logic [W2-1:0]    step_acc;
  logic             last_step;
  logic [W2-1:0]    prod_fix;
  logic [WIDTH-1:0] hi_fix, lo_fix;

  always_comb begin
    start_op     = op_e'(bus.op);
    start_signed = is_signed_op(start_op);
    start_div    = (start_op == OP_DIV) || (start_op == OP_DIVU);
    sign_rs      = start_signed & bus.rs[WIDTH-1];
    sign_rt      = start_signed & bus.rt[WIDTH-1];
    // The magnitude of the most negative value is the same bit pattern read as
    // unsigned, which is exactly what the unsigned datapath needs.
    abs_rs       = sign_rs ? -bus.rs : bus.rs;
    abs_rt       = sign_rt ? -bus.rt : bus.rt;
  end

  mdu_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_q),
    .operand (operand_q),
    .acc_i   (acc_q),
    .acc_o   (step_acc)
  );

  assign last_step = (count_q == CNT_W'(WIDTH - 1));

  // Sign correction applied to the finished accumulator.
  always_comb begin
    prod_fix = neg_res_q ? -acc_q : acc_q;
    if (is_div_q) begin
      lo_fix = neg_res_q ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
      hi_fix = neg_rem_q ? -acc_q[W2-1:WIDTH] : acc_q[W2-1:WIDTH];
    end else begin
      hi_fix = prod_fix[W2-1:WIDTH];
      lo_fix = prod_fix[WIDTH-1:0];
    end
  end

  // State register and datapath registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      is_div_q  <= 1'b0;
      neg_res_q <= 1'b0;
      neg_rem_q <= 1'b0;
      operand_q <= '0;
      acc_q     <= '0;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
    end else begin
      state_q   <= state_d;
      is_div_q  <= is_div_d;
      neg_res_q <= neg_res_d;
      neg_rem_q <= neg_rem_d;
      operand_q <= operand_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (bus.start) state_d = CALC;
      CALC:    if (last_step) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath next values.
  always_comb begin
    is_div_d  = is_div_q;
    neg_res_d = neg_res_q;
    neg_rem_d = neg_rem_q;
    operand_d = operand_q;
    acc_d     = acc_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          is_div_d  = start_div;
          neg_res_d = sign_rs ^ sign_rt;
          neg_rem_d = sign_rs;
          // Multiply iterates over the multiplier (rt) in the low half;
          // divide shifts the dividend (rs) out of the low half.
          operand_d = start_div ? abs_rt : abs_rs;
          acc_d     = {{WIDTH{1'b0}}, (start_div ? abs_rs : abs_rt)};
          count_d   = '0;
        end
      end
      CALC: begin
        acc_d   = step_acc;
        count_d = count_q + 1'b1;
      end
      FIX: begin
        // Loaded on the edge that enters DONE.
        hi_d = hi_fix;
        lo_d = lo_fix;
      end
      default: ;
    endcase
  end

  // Outputs decoded from state.
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.dbg_state = state_q;
    bus.hi_out    = hi_q;
    bus.lo_out    = lo_q;
  end

endmodule

// File: tb/tb_mult_div_unit.sv
// tb_mult_div_unit: vector table plus hand-written sequences for the
// iterative multiply/divide unit. Inputs change and outputs are sampled on
// the falling clock edge; the DUT acts on the rising edge.
module tb_mult_div_unit;
  import mult_div_pkg::*;

  localparam int W = 32;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  mult_div_if #(.WIDTH(W)) bus ();

  mult_div_unit #(.WIDTH(W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct {
    string        name;
    logic [1:0]   op;
    logic [W-1:0] rs;
    logic [W-1:0] rt;
    logic [W-1:0] exp_hi;
    logic [W-1:0] exp_lo;
  } vec_t;

  vec_t vecs[12];

  int checks = 0;
  int errors = 0;
  logic [2*W-1:0] exp_q[$];
  logic [2*W-1:0] last_result = '0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Independent reference: native signed/unsigned arithmetic plus the
  // defined divide-by-zero results.
  function automatic logic [2*W-1:0] model(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    longint sa = longint'($signed(a));
    longint sb = longint'($signed(b));
    longint q;
    longint r;
    logic [2*W-1:0] res;
    case (op)
      2'b00: res = 64'(sa * sb);
      2'b01: res = {32'd0, a} * {32'd0, b};
      2'b10: begin
        if (b == 0) res = {a, (a[W-1] ? 32'h0000_0001 : 32'hFFFF_FFFF)};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[W-1:0], q[W-1:0]};
        end
      end
      default: begin
        if (b == 0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Issues one operation, optionally re-asserting start with junk operands
  // every busy cycle, and checks latency, busy width, result stability and
  // the scoreboarded result.
  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] rs,
                        input logic [W-1:0] rt, input logic [2*W-1:0] exp, input bit hammer);
    int cyc = 0;
    int busy_cyc = 0;
    bit stable_ok = 1'b1;
    bit seen = 1'b0;
    logic [2*W-1:0] want;
    @(negedge clk);
    check({name, " idle before start"}, {62'd0, bus.busy, bus.done}, 64'd0);
    bus.start = 1'b1;
    bus.op    = op;
    bus.rs    = rs;
    bus.rt    = rt;
    exp_q.push_back(exp);
    while (cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (bus.busy) busy_cyc++;
      if (bus.done) begin
        seen = 1'b1;
        bus.start = 1'b0;
        break;
      end
      if ({bus.hi_out, bus.lo_out} !== last_result) stable_ok = 1'b0;
      bus.start = hammer;
      bus.op    = 2'($urandom_range(0, 3));
      bus.rs    = $urandom;
      bus.rt    = $urandom;
    end
    check({name, " done seen"}, 64'(seen), 64'd1);
    want = exp_q.pop_front();
    if (seen) begin
      // cyc counts falling edges after the start edge; done shows up after
      // 33 rising edges, i.e. in the 34th sampled cycle.
      check({name, " latency"}, 64'(cyc - 1), 64'd33);
      check({name, " busy cycles"}, 64'(busy_cyc), 64'd34);
      check({name, " hold before done"}, 64'(stable_ok), 64'd1);
      check({name, " result"}, {bus.hi_out, bus.lo_out}, want);
      last_result = want;
    end else begin
      bus.start = 1'b0;
    end
  endtask

  initial begin
    logic [1:0] rop;
    logic [W-1:0] ra, rb;
    bit saw_done;

    vecs[0]  = '{"multu max",    2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001};
    vecs[1]  = '{"mult -3*7",    2'b00, 32'hFFFF_FFFD, 32'd7,         32'hFFFF_FFFF, 32'hFFFF_FFEB};
    vecs[2]  = '{"mult min*min", 2'b00, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000};
    vecs[3]  = '{"div -7/2",     2'b10, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vecs[4]  = '{"divu 100/7",   2'b11, 32'd100,       32'd7,         32'd2,         32'd14};
    vecs[5]  = '{"div min/-1",   2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000};
    vecs[6]  = '{"divu 9/0",     2'b11, 32'd9,         32'd0,         32'd9,         32'hFFFF_FFFF};
    vecs[7]  = '{"div -9/0",     2'b10, 32'hFFFF_FFF7, 32'd0,         32'hFFFF_FFF7, 32'h0000_0001};
    vecs[8]  = '{"multu 5*7",    2'b01, 32'd5,         32'd7,         32'd0,         32'h0000_0023};
    vecs[9]  = '{"div 7/0",      2'b10, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF};
    vecs[10] = '{"mult 12345*-1",2'b00, 32'd12345,     32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_CFC7};
    vecs[11] = '{"div 7/-2",     2'b10, 32'd7,         32'hFFFF_FFFE, 32'd1,         32'hFFFF_FFFD};

    // Reset state.
    reset_n   = 1'b0;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.rs    = '0;
    bus.rt    = '0;
    #1;
    check("reset outputs", {bus.hi_out, bus.lo_out}, 64'd0);
    check("reset status", {62'd0, bus.busy, bus.done}, 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;

    // Directed table, issued back to back (each start lands in the cycle
    // right after the previous done).
    for (int i = 0; i < 12; i++) begin
      run_op(vecs[i].name, vecs[i].op, vecs[i].rs, vecs[i].rt, {vecs[i].exp_hi, vecs[i].exp_lo}, 1'b0);
    end

    // start hammered with new operands for the whole operation.
    run_op("divu 100/7 hammered", 2'b11, 32'd100, 32'd7, {32'd2, 32'd14}, 1'b1);

    // Results hold through idle cycles.
    saw_done = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if ({bus.hi_out, bus.lo_out} !== last_result || bus.done) saw_done = 1'b1;
    end
    check("idle hold", 64'(saw_done), 64'd0);

    // Random operations against the reference model.
    for (int i = 0; i < 10; i++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      rb  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 5)) : 32'($urandom);
      run_op($sformatf("random %0d", i), rop, ra, rb, model(rop, ra, rb), 1'b0);
    end

    // Reset in the middle of a MULTU 5*7.
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b01;
    bus.rs    = 32'd5;
    bus.rt    = 32'd7;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (10) @(negedge clk);
    check("mid calc busy", 64'(bus.busy), 64'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("async reset busy", 64'(bus.busy), 64'd0);
    check("async reset done", 64'(bus.done), 64'd0);
    check("async reset hi", 64'(bus.hi_out), 64'd0);
    check("async reset lo", 64'(bus.lo_out), 64'd0);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    last_result = '0;
    saw_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done || bus.busy) saw_done = 1'b1;
    end
    check("no done after reset", 64'(saw_done), 64'd0);
    check("idle state after reset", 64'(bus.dbg_state), 64'(IDLE));

    // Unit still works after the abandoned operation.
    run_op("div after reset", 2'b10, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD}, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
